// File: rtl/bus_dest_regs_pkg.sv
// Shared encoding for the CPU data bus: destination/source select codes and the
// write-side FSM state type.
package bus_dest_regs_pkg;

  localparam logic [3:0] LD_DATAMEM = 4'd0;
  localparam logic [3:0] LD_R       = 4'd1;
  localparam logic [3:0] LD_IR      = 4'd2;
  localparam logic [3:0] LD_RL      = 4'd3;
  localparam logic [3:0] LD_RC      = 4'd4;
  localparam logic [3:0] LD_RP      = 4'd5;
  localparam logic [3:0] LD_RQ      = 4'd6;
  localparam logic [3:0] LD_R1      = 4'd7;
  localparam logic [3:0] LD_ACC     = 4'd8;
  localparam logic [3:0] LD_IDLE    = 4'd9;

  // RC, RP, RQ, R1 occupy consecutive codes starting at LD_RC
  localparam int NUM_INC_REGS = 4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wr_state_e;

  function automatic logic is_reg_code(input logic [3:0] code);
    return (code >= LD_R) && (code <= LD_ACC);
  endfunction

endpackage

// File: rtl/bus_dest_regs_inc_reg.sv
// bus_inc_reg: loadable register with +1 increment; a load in the same cycle
// overrides the increment.
module bus_inc_reg #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             inc_en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (load_en) begin
      q_next = load_data;
    end else if (inc_en) begin
      q_next = q_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/bus_dest_regs.sv
// Bus destination side: captures bus_in into the register or memory selected by
// load_sel. Optional write statistics counter enabled by BUS_DEST_STATS_EN.
module bus_dest_regs
  import bus_dest_regs_pkg::*;
#(
  parameter int MEM_WIDTH = 12,
  parameter int INS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_WIDTH-1:0] bus_in,
  input  logic [3:0]           load_sel,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [3:0]           inc_en,
  output logic                 mem_wr_req,
  output logic [MEM_WIDTH-1:0] mem_wr_data,
  input  logic                 mem_wr_ack,
  output logic [MEM_WIDTH-1:0] R,
  output logic [MEM_WIDTH-1:0] RL,
  output logic [MEM_WIDTH-1:0] RC,
  output logic [MEM_WIDTH-1:0] RP,
  output logic [MEM_WIDTH-1:0] RQ,
  output logic [MEM_WIDTH-1:0] R1,
  output logic [MEM_WIDTH-1:0] ACC,
  output logic [INS_WIDTH-1:0] IR
`ifdef BUS_DEST_STATS_EN
  ,
  output logic [15:0]          wr_count
`endif
);

  wr_state_e            state_reg, state_next;
  logic                 mem_wr_req_reg, mem_wr_req_next;
  logic [MEM_WIDTH-1:0] mem_wr_data_reg, mem_wr_data_next;
  logic                 accept;
  logic                 mem_done;

  logic [MEM_WIDTH-1:0] r_reg, rl_reg, acc_reg;
  logic [INS_WIDTH-1:0] ir_reg;
  logic [MEM_WIDTH-1:0] inc_q [NUM_INC_REGS];

  assign load_ready = (state_reg == ST_IDLE);
  assign accept     = load_valid && load_ready;
  assign mem_done   = (state_reg == ST_MEM_WAIT) && mem_wr_ack;

  always_comb begin
    state_next       = state_reg;
    mem_wr_req_next  = mem_wr_req_reg;
    mem_wr_data_next = mem_wr_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && (load_sel == LD_DATAMEM)) begin
          state_next       = ST_MEM_WAIT;
          mem_wr_req_next  = 1'b1;
          mem_wr_data_next = bus_in;
        end
      end
      ST_MEM_WAIT: begin
        // request and data stay frozen until the memory acknowledges
        if (mem_wr_ack) begin
          state_next      = ST_IDLE;
          mem_wr_req_next = 1'b0;
        end
      end
      default: begin
        state_next      = ST_IDLE;
        mem_wr_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      mem_wr_req_reg  <= 1'b0;
      mem_wr_data_reg <= '0;
    end else begin
      state_reg       <= state_next;
      mem_wr_req_reg  <= mem_wr_req_next;
      mem_wr_data_reg <= mem_wr_data_next;
    end
  end

  assign mem_wr_req  = mem_wr_req_reg;
  assign mem_wr_data = mem_wr_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg   <= '0;
      rl_reg  <= '0;
      acc_reg <= '0;
      ir_reg  <= '0;
    end else if (accept) begin
      case (load_sel)
        LD_R:    r_reg   <= bus_in;
        LD_RL:   rl_reg  <= bus_in;
        LD_ACC:  acc_reg <= bus_in;
        LD_IR:   ir_reg  <= bus_in[INS_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INC_REGS; gi++) begin : g_inc
      bus_inc_reg #(
        .WIDTH(MEM_WIDTH)
      ) u_inc_reg (
        .clk      (clk),
        .rst      (rst),
        .load_en  (accept && (load_sel == (LD_RC + 4'(gi)))),
        .inc_en   (inc_en[gi]),
        .load_data(bus_in),
        .q        (inc_q[gi])
      );
    end
  endgenerate

  assign R   = r_reg;
  assign RL  = rl_reg;
  assign ACC = acc_reg;
  assign IR  = ir_reg;
  assign RC  = inc_q[0];
  assign RP  = inc_q[1];
  assign RQ  = inc_q[2];
  assign R1  = inc_q[3];

`ifdef BUS_DEST_STATS_EN
  logic [15:0] wr_count_reg;

  // counts register loads and completed memory writes, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_reg <= '0;
    end else if (((accept && is_reg_code(load_sel)) || mem_done) &&
                 (wr_count_reg != 16'hFFFF)) begin
      wr_count_reg <= wr_count_reg + 16'd1;
    end
  end

  assign wr_count = wr_count_reg;
`else
  logic unused_mem_done;
  assign unused_mem_done = mem_done;
`endif

endmodule

// File: tb/tb_bus_dest_regs.sv
// Directed self-checking bench for bus_dest_regs; the statistics scenario runs
// only when BUS_DEST_STATS_EN is defined.
module tb_bus_dest_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] bus_in = '0;
  logic [3:0]  load_sel = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  inc_en = '0;
  logic        mem_wr_req;
  logic [11:0] mem_wr_data;
  logic        mem_wr_ack = 1'b0;
  logic [11:0] R, RL, RC, RP, RQ, R1, ACC;
  logic [7:0]  IR;
`ifdef BUS_DEST_STATS_EN
  logic [15:0] wr_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_dest_regs #(.MEM_WIDTH(12), .INS_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .load_sel   (load_sel),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .inc_en     (inc_en),
    .mem_wr_req (mem_wr_req),
    .mem_wr_data(mem_wr_data),
    .mem_wr_ack (mem_wr_ack),
    .R          (R),
    .RL         (RL),
    .RC         (RC),
    .RP         (RP),
    .RQ         (RQ),
    .R1         (R1),
    .ACC        (ACC),
    .IR         (IR)
`ifdef BUS_DEST_STATS_EN
    ,
    .wr_count   (wr_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] reg_by_code(input logic [3:0] c);
    case (c)
      4'd1: return R;
      4'd3: return RL;
      4'd4: return RC;
      4'd5: return RP;
      4'd6: return RQ;
      4'd7: return R1;
      4'd8: return ACC;
      default: return 12'h000;
    endcase
  endfunction

  task automatic load(input logic [3:0] sel, input logic [11:0] val);
    load_sel = sel;
    bus_in = val;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({R, RL, RC, RP, RQ, R1, ACC, IR, mem_wr_data} !== '0 || mem_wr_req !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: regs_or=%0h req=%b ready=%b required regs 0 req 0 ready 1",
               R | RL | RC | RP | RQ | R1 | ACC | {4'h0, IR} | mem_wr_data, mem_wr_req, load_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: regs cleared, load_ready=%b", load_ready);
  endtask

  task automatic test_reg_load();
    logic [3:0]  codes [6] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [11:0] vals  [6] = '{12'h333, 12'h444, 12'h555, 12'h666, 12'h777, 12'h888};
    load(4'd1, 12'hABC);
    total++;
    if (R !== 12'hABC) begin
      bad++;
      $display("FAIL load_R: got %h required abc", R);
    end
    total++;
    if ({RL, RC, RP, RQ, R1, ACC, IR} !== '0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_R_others: others nonzero or ready=%b required 0 / ready 1", load_ready);
    end
    $display("load sel=1 bus=abc -> R=%h", R);
    for (int i = 0; i < 6; i++) begin
      load(codes[i], vals[i]);
      total++;
      if (reg_by_code(codes[i]) !== vals[i]) begin
        bad++;
        $display("FAIL load_code%0d: got %h required %h", codes[i], reg_by_code(codes[i]), vals[i]);
      end
      $display("load sel=%0d bus=%h -> reg=%h", codes[i], vals[i], reg_by_code(codes[i]));
    end
    for (int c = 9; c < 16; c++) begin
      load(4'(c), 12'hFFF);
    end
    total++;
    if (R !== 12'hABC || ACC !== 12'h888 || RC !== 12'h444 || IR !== 8'h00 || mem_wr_req !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_codes: R=%h ACC=%h RC=%h IR=%h req=%b ready=%b required abc 888 444 00 0 1",
               R, ACC, RC, IR, mem_wr_req, load_ready);
    end
    $display("idle codes 9-15 bus=fff -> no effect R=%h ACC=%h", R, ACC);
  endtask

  task automatic test_ir();
    load(4'd2, 12'hF5A);
    total++;
    if (IR !== 8'h5A) begin
      bad++;
      $display("FAIL load_IR: got %h required 5a", IR);
    end
    $display("load sel=2 bus=f5a -> IR=%h", IR);
  endtask

  task automatic test_inc();
    load(4'd4, 12'hFFF);
    inc_en = 4'b0001;
    tick();
    inc_en = 4'b0000;
    total++;
    if (RC !== 12'h000) begin
      bad++;
      $display("FAIL inc_wrap: RC=%h required 000", RC);
    end
    $display("inc RC from fff -> %h", RC);
    inc_en = 4'b0001;
    load(4'd4, 12'h010);
    inc_en = 4'b0000;
    total++;
    if (RC !== 12'h010) begin
      bad++;
      $display("FAIL load_beats_inc: RC=%h required 010", RC);
    end
    $display("load+inc RC bus=010 -> %h", RC);
    inc_en = 4'b1110;
    tick();
    inc_en = 4'b0000;
    total++;
    if (RC !== 12'h010 || RP !== 12'h556 || RQ !== 12'h667 || R1 !== 12'h778) begin
      bad++;
      $display("FAIL inc_multi: RC=%h RP=%h RQ=%h R1=%h required 010 556 667 778", RC, RP, RQ, R1);
    end
    $display("inc_en=1110 -> RP=%h RQ=%h R1=%h", RP, RQ, R1);
  endtask

  task automatic test_mem_write();
    int high_cycles = 0;
    load(4'd0, 12'h123);
    load_sel = 4'd1;
    bus_in = 12'h777;
    load_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (mem_wr_req !== 1'b1 || mem_wr_data !== 12'h123 || load_ready !== 1'b0) begin
        bad++;
        $display("FAIL mem_wait_c%0d: req=%b data=%h ready=%b required 1 123 0", i, mem_wr_req, mem_wr_data, load_ready);
      end
      if (mem_wr_req === 1'b1) high_cycles++;
      inc_en = (i == 2) ? 4'b0010 : 4'b0000;
      if (i == 4) mem_wr_ack = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    mem_wr_ack = 1'b0;
    inc_en = 4'b0000;
    total++;
    if (mem_wr_req !== 1'b0 || load_ready !== 1'b1 || high_cycles != 4) begin
      bad++;
      $display("FAIL mem_done: req=%b ready=%b high=%0d required 0 1 4", mem_wr_req, load_ready, high_cycles);
    end
    total++;
    if (R !== 12'hABC || RP !== 12'h557) begin
      bad++;
      $display("FAIL mem_wait_side: R=%h RP=%h required abc 557", R, RP);
    end
    $display("mem write 123: req high %0d cycles, R=%h RP=%h", high_cycles, R, RP);
  endtask

  task automatic test_ack_idle();
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    total++;
    if (mem_wr_req !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL ack_in_idle: req=%b ready=%b required 0 1", mem_wr_req, load_ready);
    end
    $display("ack in idle -> req=%b ready=%b", mem_wr_req, load_ready);
  endtask

  task automatic test_reset_mid_wait();
    load(4'd0, 12'h5A5);
    total++;
    if (mem_wr_req !== 1'b1 || load_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre: req=%b ready=%b required 1 0", mem_wr_req, load_ready);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (mem_wr_req !== 1'b0 || mem_wr_data !== 12'h000 || {R, RC, RP, ACC} !== '0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_async: req=%b data=%h R=%h RC=%h ready=%b required 0 000 000 000 1",
               mem_wr_req, mem_wr_data, R, RC, load_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if (mem_wr_req !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release: req=%b ready=%b required 0 1", mem_wr_req, load_ready);
    end
    $display("reset during mem wait -> req=%b ready=%b", mem_wr_req, load_ready);
  endtask

`ifdef BUS_DEST_STATS_EN
  task automatic test_stats();
    load(4'd1, 12'h001);
    load(4'd3, 12'h002);
    load(4'd8, 12'h003);
    load(4'd0, 12'h004);
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    load(4'd9, 12'h005);
    load(4'd12, 12'h006);
    total++;
    if (wr_count !== 16'd4) begin
      bad++;
      $display("FAIL wr_count: got %0d required 4", wr_count);
    end
    $display("stats: wr_count=%0d", wr_count);
  endtask
`endif

  initial begin
    test_reset();
    test_reg_load();
    test_ir();
    test_inc();
    test_mem_write();
    test_ack_idle();
    test_reset_mid_wait();
`ifdef BUS_DEST_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
